// File: rtl/kw_arb_pkg.sv
// Shared types and helpers for the kw stream arbiter and other round-robin schedulers.
//   STAT_W        width of each per-requester packet-completion counter
//   ARB_MAX_REQ   largest requester count the helpers support
//   ARB_IDX_MAX_W index width used inside arb_state_t
//   arb_state_t   {lock, lock_idx, rr_ptr}: arbitration state held by the top level
//   rr_first      first set bit of valid, scanning from ptr+1 with wrap-around
package kw_arb_pkg;

  localparam int unsigned STAT_W        = 32;
  localparam int unsigned ARB_MAX_REQ   = 32;
  localparam int unsigned ARB_IDX_MAX_W = 5;

  typedef struct packed {
    logic                     lock;
    logic [ARB_IDX_MAX_W-1:0] lock_idx;
    logic [ARB_IDX_MAX_W-1:0] rr_ptr;
  } arb_state_t;

  // Index of the first set bit in valid[num_req-1:0], starting the scan just
  // after ptr. Returns 0 when nothing is set; callers qualify with |valid.
  function automatic int unsigned rr_first(
    input logic [ARB_MAX_REQ-1:0] valid,
    input int unsigned            ptr,
    input int unsigned            num_req
  );
    int unsigned idx;
    int unsigned k;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 1; i <= num_req; i++) begin
      k = (ptr + i) % num_req;
      if (!found && valid[k[ARB_IDX_MAX_W-1:0]]) begin
        idx   = k;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/kw_rr_pick.sv
// Purely combinational round-robin picker.
//   valid  in  NUM_REQ  request vector
//   ptr    in  IDX_W    last winner; the scan starts at ptr+1 and wraps
//   idx    out IDX_W    index of the first set valid bit after ptr
//   any    out 1        at least one valid bit set (idx meaningful only then)
module kw_rr_pick
  import kw_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [ARB_MAX_REQ-1:0] valid_ext;
  int unsigned            ptr_int;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    ptr_int                  = int'(ptr);
    idx                      = IDX_W'(rr_first(valid_ext, ptr_int, NUM_REQ));
    any                      = |valid;
  end

endmodule

// File: rtl/kw_stream_arbiter.sv
// Round-robin, packet-locked arbiter sharing one ready/valid sink between
// NUM_REQ ready/valid requesters, with a registered output stage
// (1-cycle latency, 1 beat/cycle). NUM_REQ must be 2..32.
//   clock, reset         clock; synchronous active-high reset
//   i_valid/i_ready      per-requester handshake (i_ready one-hot or zero)
//   i_last               per-requester end-of-packet
//   i_data               per-requester payload, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_valid/o_ready      output handshake
//   o_data/o_last/o_src  registered output beat and the index of its requester
//   o_grant_cnt          only with KW_STREAM_ARB_STATS_EN: NUM_REQ saturating
//                        32-bit packet-completion counters, requester k at [k*32 +: 32]
module kw_stream_arbiter
  import kw_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 16,
  localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i_valid,
  output logic [NUM_REQ-1:0]            i_ready,
  input  logic [NUM_REQ-1:0]            i_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_last,
  output logic [IDX_W-1:0]              o_src
`ifdef KW_STREAM_ARB_STATS_EN
 ,output logic [NUM_REQ*STAT_W-1:0]     o_grant_cnt
`endif
);

  arb_state_t            st_q, st_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic [IDX_W-1:0]      o_src_q, o_src_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IDX_W-1:0]      rr_ptr_idx;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  load;
  logic                  grant;
  logic                  accept;
  logic [IDX_W-1:0]      sel;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign data_arr[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rr_ptr_idx = IDX_W'(st_q.rr_ptr);

  kw_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (i_valid),
    .ptr   (rr_ptr_idx),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    load     = !o_valid_q || o_ready;
    // A locked packet keeps its grant even through a bubble on its valid.
    sel      = st_q.lock ? IDX_W'(st_q.lock_idx) : pick_idx;
    grant    = load && (st_q.lock || pick_any) && !reset;
    i_ready  = '0;
    if (grant) begin
      i_ready[sel] = 1'b1;
    end
    accept   = grant && i_valid[sel];
    sel_last = i_last[sel];
    sel_data = data_arr[sel];

    st_d      = st_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_src_d   = o_src_q;

    if (load) begin
      o_valid_d = accept;
      if (accept) begin
        o_data_d = sel_data;
        o_last_d = sel_last;
        o_src_d  = sel;
      end
    end

    if (accept) begin
      if (sel_last) begin
        st_d.lock   = 1'b0;
        st_d.rr_ptr = ARB_IDX_MAX_W'(sel);
      end else begin
        st_d.lock     = 1'b1;
        st_d.lock_idx = ARB_IDX_MAX_W'(sel);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q.lock     <= 1'b0;
      st_q.lock_idx <= '0;
      st_q.rr_ptr   <= ARB_IDX_MAX_W'(NUM_REQ - 1);
      o_valid_q     <= 1'b0;
      o_data_q      <= '0;
      o_last_q      <= 1'b0;
      o_src_q       <= '0;
    end else begin
      st_q      <= st_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_src_q   <= o_src_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign o_src   = o_src_q;

`ifdef KW_STREAM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];
  logic [STAT_W-1:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cnt_d[k] = cnt_q[k];
      if (accept && sel_last && (int'(sel) == k) && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + STAT_W'(1);
      end
      o_grant_cnt[k*STAT_W +: STAT_W] = cnt_q[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Requester protocol: a raised valid holds with stable payload until accepted.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req_rules
    a_req_hold: assert property (@(posedge clock) disable iff (reset)
      (i_valid[k] && !i_ready[k]) |=>
        (i_valid[k] && $stable(i_last[k]) &&
         $stable(i_data[k*DATA_WIDTH +: DATA_WIDTH])));
  end

  a_ready_onehot: assert property (@(posedge clock) $onehot0(i_ready));

endmodule
